seq_alu: RTL

Parametrised multi-cycle integer ALU for the RISC-V core's execute stage. It keeps the existing 4-bit opcode map and adds a valid/ready handshake on both sides. Logic, shift and compare ops finish in one cycle. Multiply, high multiply and signed/unsigned divide/remainder run as iterative shift-add and restoring-division engines over XLEN cycles, with correct RISC-V signed semantics, divide-by-zero and overflow results, and a synchronous flush.

---
 rtl/seq_alu.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Multi-cycle integer ALU: single-cycle logic/shift/compare, iterative shift-add multiply and restoring divide.
// Latency: 1 cycle for single-cycle ops and divide special cases, XLEN+1 cycles for mul/mulh/div/rem/divu/remu.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so at most one op is in flight.
module seq_alu #(
    parameter int XLEN = 64,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] X,
    input  logic [XLEN-1:0] Y,
    input  logic [3:0]      OP,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] OUTPUT,
    output logic            isEqual
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_MULH = 4'd9;
    localparam logic [3:0] OP_DIV  = 4'd10;
    localparam logic [3:0] OP_REM  = 4'd11;
    localparam logic [3:0] OP_SLT  = 4'd12;
    localparam logic [3:0] OP_SLTU = 4'd13;
    localparam logic [3:0] OP_DIVU = 4'd14;
    localparam logic [3:0] OP_REMU = 4'd15;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   count, count_n;
    logic [3:0]      op_q, op_n;
    logic [XLEN-1:0] hi, hi_n;
    logic [XLEN-1:0] lo, lo_n;
    logic [XLEN-1:0] opb, opb_n;
    logic            neg, neg_n;
    logic [XLEN-1:0] out_q, out_n;
    logic            eq_q, eq_n;

    // Accept-side decode and operand magnitudes
    logic            is_mul, is_div, sgn_op, rem_op, x_neg, y_neg, last;
    logic [XLEN-1:0] x_mag, y_mag, alu_res;
    logic [SHW-1:0]  shamt;

    always_comb begin
        is_mul = (OP == OP_MUL) || (OP == OP_MULH);
        is_div = (OP == OP_DIV) || (OP == OP_REM) || (OP == OP_DIVU) || (OP == OP_REMU);
        sgn_op = (OP == OP_MULH) || (OP == OP_DIV) || (OP == OP_REM);
        rem_op = (OP == OP_REM) || (OP == OP_REMU);
        x_neg  = sgn_op && X[XLEN-1];
        y_neg  = sgn_op && Y[XLEN-1];
        x_mag  = x_neg ? (~X + 1'b1) : X;
        y_mag  = y_neg ? (~Y + 1'b1) : Y;
        last   = (count == CW'(XLEN-1));
    end

    always_comb begin
        alu_res = '0;
        shamt   = Y[SHW-1:0];
        case (OP)
            OP_ADD:  alu_res = X + Y;
            OP_SUB:  alu_res = X - Y;
            OP_AND:  alu_res = X & Y;
            OP_OR:   alu_res = X | Y;
            OP_XOR:  alu_res = X ^ Y;
            OP_SLL:  alu_res = X << shamt;
            OP_SRL:  alu_res = X >> shamt;
            OP_SRA:  alu_res = XLEN'($signed(X) >>> shamt);
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(X) < $signed(Y))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (X < Y)};
            default: alu_res = '0;
        endcase
    end

    // Multiply step: {hi,lo} is the accumulator, lo starts as the multiplier and shifts out LSB-first
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_hi, mul_lo;
    logic [2*XLEN-1:0] prod, prod_fix;

    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
        mul_hi   = mul_sum[XLEN:1];
        mul_lo   = {mul_sum[0], lo[XLEN-1:1]};
        prod     = {mul_hi, mul_lo};
        prod_fix = neg ? (~prod + 1'b1) : prod;
    end

    // Restoring divide step: hi is the partial remainder, lo shifts dividend out and quotient in
    logic [XLEN:0]   div_sh, div_diff;
    logic            div_ok;
    logic [XLEN-1:0] div_hi, div_lo, div_res, div_fix;

    always_comb begin
        div_sh   = {hi, lo[XLEN-1]};
        div_diff = div_sh - {1'b0, opb};
        div_ok   = ~div_diff[XLEN];
        div_hi   = div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
        div_lo   = {lo[XLEN-2:0], div_ok};
        div_res  = ((op_q == OP_REM) || (op_q == OP_REMU)) ? div_hi : div_lo;
        div_fix  = neg ? (~div_res + 1'b1) : div_res;
    end

    always_comb begin
        state_n = state;
        count_n = count;
        op_n    = op_q;
        hi_n    = hi;
        lo_n    = lo;
        opb_n   = opb;
        neg_n   = neg;
        out_n   = out_q;
        eq_n    = eq_q;
        if (flush) begin
            state_n = IDLE;
            count_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_n    = OP;
                        eq_n    = (X == Y);
                        count_n = '0;
                        if (is_mul) begin
                            state_n = MUL;
                            hi_n    = '0;
                            lo_n    = y_mag;
                            opb_n   = x_mag;
                            neg_n   = x_neg ^ y_neg;
                        end else if (is_div) begin
                            if (Y == '0) begin
                                state_n = DONE;
                                out_n   = rem_op ? X : '1;
                            end else if (sgn_op && (X == MIN_VAL) && (Y == '1)) begin
                                state_n = DONE;
                                out_n   = rem_op ? '0 : MIN_VAL;
                            end else begin
                                state_n = DIV;
                                hi_n    = '0;
                                lo_n    = x_mag;
                                opb_n   = y_mag;
                                neg_n   = rem_op ? x_neg : (x_neg ^ y_neg);
                            end
                        end else begin
                            state_n = DONE;
                            out_n   = alu_res;
                        end
                    end
                end
                MUL: begin
                    hi_n    = mul_hi;
                    lo_n    = mul_lo;
                    count_n = count + 1'b1;
                    if (last) begin
                        state_n = DONE;
                        count_n = '0;
                        out_n   = (op_q == OP_MULH) ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
                    end
                end
                DIV: begin
                    hi_n    = div_hi;
                    lo_n    = div_lo;
                    count_n = count + 1'b1;
                    if (last) begin
                        state_n = DONE;
                        count_n = '0;
                        out_n   = div_fix;
                    end
                end
                DONE: begin
                    if (out_ready) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            op_q  <= '0;
            hi    <= '0;
            lo    <= '0;
            opb   <= '0;
            neg   <= 1'b0;
            out_q <= '0;
            eq_q  <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            op_q  <= op_n;
            hi    <= hi_n;
            lo    <= lo_n;
            opb   <= opb_n;
            neg   <= neg_n;
            out_q <= out_n;
            eq_q  <= eq_n;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign OUTPUT    = out_q;
    assign isEqual   = eq_q;

endmodule
